// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - synchronous modulo-MOD up/down counter with load, clear, wrap/saturate and TC/ZERO flags
module sync_updown_counter #(
  parameter int WIDTH     = 3,
  parameter int MOD       = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             zero_o
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("sync_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_reset_val
    $error("sync_updown_counter: RESET_VAL must be below MOD");
  end

  // One extra bit so MOD = 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (clr_i) begin
      q_d = RST_V;
    end else if (load_i) begin
      q_d = ({1'b0, d_i} >= MOD_W) ? TOP_V : d_i;
    end else if (en_i) begin
      if (up_i) begin
        if (q_q == TOP_V) begin
          tc_d = 1'b1;
          q_d  = SAT ? TOP_V : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          tc_d = 1'b1;
          q_d  = SAT ? '0 : TOP_V;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q  <= RST_V;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q_o    = q_q;
  assign tc_o   = tc_q;
  assign zero_o = (q_q == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb/tb_sync_updown_counter.sv - directed and randomised checks of sync_updown_counter in several configurations
`timescale 1ns/1ps
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n, clr, load, en, up;
  logic [3:0] d;

  logic [2:0] q_a, q_b, q_c;
  logic [3:0] q_d, q_e;
  logic       tc_a, tc_b, tc_c, tc_d, tc_e;
  logic       z_a, z_b, z_c, z_d, z_e;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(3), .MOD(8), .SATURATE(0), .RESET_VAL(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .d_i(d[2:0]),
    .en_i(en), .up_i(up), .q_o(q_a), .tc_o(tc_a), .zero_o(z_a));
  sync_updown_counter #(.WIDTH(3), .MOD(6), .SATURATE(0), .RESET_VAL(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .d_i(d[2:0]),
    .en_i(en), .up_i(up), .q_o(q_b), .tc_o(tc_b), .zero_o(z_b));
  sync_updown_counter #(.WIDTH(3), .MOD(8), .SATURATE(1), .RESET_VAL(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .d_i(d[2:0]),
    .en_i(en), .up_i(up), .q_o(q_c), .tc_o(tc_c), .zero_o(z_c));
  sync_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RESET_VAL(0)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .d_i(d),
    .en_i(en), .up_i(up), .q_o(q_d), .tc_o(tc_d), .zero_o(z_d));
  sync_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1), .RESET_VAL(0)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .d_i(d),
    .en_i(en), .up_i(up), .q_o(q_e), .tc_o(tc_e), .zero_o(z_e));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge and DUT outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic c, input logic l, input logic [3:0] dv,
                        input logic e, input logic u);
    clr = c; load = l; d = dv; en = e; up = u;
  endtask

  // Reference model for the MOD=10 random configurations.
  function automatic void model_step(input bit sat, inout int q, inout int tc);
    if (clr) begin
      q = 0; tc = 0;
    end else if (load) begin
      q = (d >= 10) ? 9 : int'(d); tc = 0;
    end else if (en && up) begin
      if (q == 9) begin tc = 1; q = sat ? 9 : 0; end
      else begin q = q + 1; tc = 0; end
    end else if (en) begin
      if (q == 0) begin tc = 1; q = sat ? 0 : 9; end
      else begin q = q - 1; tc = 0; end
    end else begin
      tc = 0;
    end
  endfunction

  initial begin
    int mq_d, mtc_d, mq_e, mtc_e;
    rst_n = 1'b0;
    set_in(0, 0, 4'd0, 0, 0);
    #12;
    chk("reset_q", q_a, 0);
    chk("reset_tc", tc_a, 0);
    chk("reset_zero", z_a, 1);
    rst_n = 1'b1;

    // Reset mid-operation
    set_in(0, 0, 4'd0, 1, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("t1_count5", q_a, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_q", q_a, 0);
    chk("t1_async_tc", tc_a, 0);
    rst_n = 1'b1;
    up = 1'b0;
    tick();
    chk("t1_down_wrap_q", q_a, 7);
    chk("t1_down_wrap_tc", tc_a, 1);

    // Down wrap, MOD=8
    pulse_reset();
    set_in(0, 0, 4'd0, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("t2_q", q_a, (8 - (k % 8)) % 8);
      chk("t2_tc", tc_a, (k == 1 || k == 9) ? 1 : 0);
      chk("t2_zero", z_a, (k == 8) ? 1 : 0);
    end

    // Up wrap, MOD=6
    pulse_reset();
    set_in(0, 0, 4'd0, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t3_q", q_b, k % 6);
      chk("t3_tc", tc_b, (k == 6) ? 1 : 0);
    end

    // Saturate, MOD=8
    set_in(0, 1, 4'd2, 0, 0);
    tick();
    chk("t4_load", q_c, 2);
    set_in(0, 0, 4'd0, 1, 0);
    tick(); chk("t4_q1", q_c, 1); chk("t4_tc1", tc_c, 0);
    tick(); chk("t4_q0", q_c, 0); chk("t4_tc0", tc_c, 0);
    tick(); chk("t4_hold_q", q_c, 0); chk("t4_hold_tc", tc_c, 1);
    tick(); chk("t4_hold2_q", q_c, 0); chk("t4_hold2_tc", tc_c, 1);
    up = 1'b1;
    tick(); chk("t4_up_q", q_c, 1); chk("t4_up_tc", tc_c, 0);

    // Priority and clamp, MOD=6
    set_in(0, 1, 4'd3, 1, 1);
    tick(); chk("t5_load3", q_b, 3); chk("t5_load3_tc", tc_b, 0);
    set_in(0, 1, 4'd7, 1, 1);
    tick(); chk("t5_clamp", q_b, 5);
    set_in(0, 1, 4'd6, 0, 0);
    tick(); chk("t5_clamp6", q_b, 5);
    set_in(1, 1, 4'd4, 1, 1);
    tick(); chk("t5_clr_over_load", q_b, 0);
    set_in(0, 1, 4'd4, 0, 0);
    tick();
    set_in(0, 0, 4'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      up = ~up;
      tick();
      chk("t5_hold_q", q_b, 4);
      chk("t5_hold_tc", tc_b, 0);
    end

    // Random, MOD=10 both modes
    pulse_reset();
    set_in(0, 0, 4'd0, 0, 0);
    mq_d = 0; mtc_d = 0; mq_e = 0; mtc_e = 0;
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(99) >= 2);
      clr   = ($urandom_range(99) < 5);
      load  = ($urandom_range(99) < 10);
      d     = 4'($urandom_range(15));
      en    = ($urandom_range(99) < 75);
      up    = $urandom_range(1) != 0;
      if (!rst_n) begin
        mq_d = 0; mtc_d = 0; mq_e = 0; mtc_e = 0;
        #1;
        chk("t6_async_q", q_d, 0);
        chk("t6_async_tc", tc_e, 0);
        #1;
        rst_n = 1'b1;
      end
      tick();
      model_step(1'b0, mq_d, mtc_d);
      model_step(1'b1, mq_e, mtc_e);
      chk("t6_wrap_q", q_d, mq_d);
      chk("t6_wrap_tc", tc_d, mtc_d);
      chk("t6_wrap_zero", z_d, (mq_d == 0) ? 1 : 0);
      chk("t6_sat_q", q_e, mq_e);
      chk("t6_sat_tc", tc_e, mtc_e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
